keypad_scan4: RTL and testbench

- Scanned 4x4 matrix-keypad reader for the washer front panel; the input-side counterpart of the multiplexed 4-digit display scanner.
- Drives one keypad column low at a time and samples the active-low rows.
- Debounces whole scan frames and emits a single-cycle key event with a 4-bit code.
- The washer controller consumes these events in place of raw switch levels.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_sync.sv | 25 ++
 rtl/keypad_scan4.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scan4.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   kp_state_e : key-acceptance FSM states
//   key_evt_t  : next-cycle key event (valid pulse + code)
//   NCOLS/NROWS/FRAME_W, COL_RST (column drive after reset)
//   key_index(): bit index of the lowest set bit of a frame
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LOCKED  = 2'd2
  } kp_state_e;

  localparam int NCOLS   = 4;
  localparam int NROWS   = 4;
  localparam int FRAME_W = NCOLS * NROWS;

  localparam logic [NCOLS-1:0] COL_RST = 4'b1110;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } key_evt_t;

  // Only called on one-hot frames, so "lowest set bit" is the key number.
  function automatic logic [3:0] key_index(input logic [FRAME_W-1:0] f);
    logic [3:0] idx;
    idx = '0;
    for (int i = FRAME_W - 1; i >= 0; i--)
      if (f[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchroniser for asynchronous inputs.
//   clk, rst (async, active-low) ; d : async input ; q : synchronised output
// Resets to all-ones so idle (pulled-up) rows do not read as presses.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/keypad_scan4.sv
// keypad_scan4: scanned 4x4 matrix-keypad reader.
//   clk, rst  : clock, async active-low reset
//   row[3:0]  : active-low rows (async)
//   col[3:0]  : one-hot active-low column drive
//   key_code  : code (col*4+row) of last accepted key
//   key_valid : one-cycle pulse per accepted press (or repeat)
//   key_held  : accepted single key still debounced-pressed
// Optional macro KEYPAD_REPEAT_EN: auto-repeat pulses while a key is held
// (first after REPEAT_DELAY frames, then every REPEAT_RATE frames).
module keypad_scan4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  // ---------------------------------------------------------------- scan
  logic [NROWS-1:0]   row_s, rows_dn;
  logic [DW-1:0]      div;
  logic [1:0]         cidx;
  logic               slot_end, frame_end;
  logic [FRAME_W-1:0] raw, raw_nx, prev, deb;
  logic [CW-1:0]      stable_cnt, stable_nx;

  keypad_sync #(.W(NROWS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  assign rows_dn   = ~row_s;
  assign slot_end  = (div == DW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (cidx == 2'd3);
  assign col       = ~(NCOLS'(1) << cidx);

  // Raw frame including this cycle's sample, so the frame boundary can
  // debounce against the complete frame without an extra cycle.
  always_comb begin
    raw_nx = raw;
    if (slot_end) raw_nx[{cidx, 2'b00} +: NROWS] = rows_dn;
  end

  always_comb begin
    stable_nx = '0;
    if (raw_nx == prev)
      stable_nx = (stable_cnt == CW'(DEBOUNCE_SCANS - 1)) ? stable_cnt
                                                          : stable_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div        <= '0;
      cidx       <= '0;
      raw        <= '0;
      prev       <= '0;
      deb        <= '0;
      stable_cnt <= '0;
    end else begin
      raw <= raw_nx;
      if (slot_end) begin
        div  <= '0;
        cidx <= cidx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
      if (frame_end) begin
        prev       <= raw_nx;
        stable_cnt <= stable_nx;
        if (stable_nx == CW'(DEBOUNCE_SCANS - 1)) deb <= raw_nx;
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  kp_state_e          state, state_nx;
  logic               one_hot, multi;
  logic [FRAME_W-1:0] held_pat;
  key_evt_t           evt_nx;
  logic               held_nx;
  logic               rpt_hit;

  assign one_hot  = (deb != '0) && ((deb & (deb - 1'b1)) == '0);
  assign multi    = (deb != '0) && !one_hot;
  assign held_pat = FRAME_W'(1) << key_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_cnt, rpt_tgt;
  logic          rpt_first;

  assign rpt_tgt = rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
  assign rpt_hit = frame_end && (state == PRESSED) && (rpt_cnt + 1'b1 == rpt_tgt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (state != PRESSED) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (frame_end) begin
      if (rpt_hit) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign rpt_hit        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (one_hot)    state_nx = PRESSED;
        else if (multi) state_nx = LOCKED;
      end
      PRESSED: begin
        if (deb == '0)            state_nx = IDLE;
        else if (deb != held_pat) state_nx = LOCKED;
      end
      LOCKED: begin
        if (deb == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Press events only fire on the IDLE->PRESSED edge, so a held key gives
  // one event; repeats reuse the stored code.
  always_comb begin
    evt_nx.valid = 1'b0;
    evt_nx.code  = key_code;
    held_nx      = (state_nx == PRESSED);
    if (state == IDLE && one_hot) begin
      evt_nx.valid = 1'b1;
      evt_nx.code  = key_index(deb);
    end else if (rpt_hit) begin
      evt_nx.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= evt_nx.valid;
      key_code  <= evt_nx.code;
      key_held  <= held_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scan4.sv
module tb_keypad_scan4;

  localparam int SD = 4, DB = 3, RD = 2, RR = 1, FR = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;
  logic [15:0] keys = '0;

  keypad_scan4 #(
    .SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row[r] = 1'b0;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Frame-level reference model: history of raw frames, debounced value,
  // acceptance flags; events predicted for the following frame.
  logic [15:0] hist[$];
  logic [15:0] m_deb;
  bit          m_held, m_locked, m_rfirst;
  logic [3:0]  m_code;
  int          m_rn;
  bit          exp_rpt, exp_press, held_old;

  task automatic model_reset();
    hist = {};
    hist.push_back(16'h0);   // reset "previous frame" of zeros
    m_deb = '0; m_held = 0; m_locked = 0; m_code = '0;
    m_rn = 0; m_rfirst = 1;
    exp_rpt = 0; exp_press = 0; held_old = 0;
  endtask

  task automatic model_frame(input logic [15:0] k);
    bit same;
    int pop;
    exp_rpt = 0; exp_press = 0; held_old = m_held;
`ifdef KEYPAD_REPEAT_EN
    if (m_held) begin
      m_rn++;
      if (m_rn == (m_rfirst ? RD : RR)) begin
        exp_rpt = 1; m_rn = 0; m_rfirst = 0;
      end
    end
`endif
    hist.push_back(k);
    while (hist.size() > DB) void'(hist.pop_front());
    if (hist.size() == DB) begin
      same = 1;
      foreach (hist[i]) if (hist[i] != k) same = 0;
      if (same) m_deb = k;
    end
    pop = $countones(m_deb);
    if (m_held) begin
      if (m_deb == 0) m_held = 0;
      else if (m_deb != (16'h1 << m_code)) begin m_held = 0; m_locked = 1; end
    end else if (m_locked) begin
      if (m_deb == 0) m_locked = 0;
    end else if (pop == 1) begin
      m_held = 1; exp_press = 1;
      for (int i = 0; i < 16; i++) if (m_deb[i]) m_code = 4'(i);
    end else if (pop > 1) begin
      m_locked = 1;
    end
    if (!m_held) begin m_rn = 0; m_rfirst = 1; end
  endtask

  // One scan frame with key set k; called at the negedge of the frame's first cycle.
  task automatic run_frame(input logic [15:0] k);
    bit exp_v;
    for (int i = 0; i < FR; i++) begin
      if (i == 0) keys = k;
      exp_v = (i == 0 && exp_rpt) || (i == 1 && exp_press);
      chk("key_valid", {31'b0, key_valid}, {31'b0, exp_v});
      if (exp_v) chk("key_code_evt", {28'b0, key_code}, {28'b0, m_code});
      if (i % SD == 0) chk("col", {28'b0, col}, {28'b0, ~(4'b0001 << (i / SD))});
      if (i == 0) chk("key_held_old", {31'b0, key_held}, {31'b0, held_old});
      if (i == 3) begin
        chk("key_held", {31'b0, key_held}, {31'b0, m_held});
        chk("key_code", {28'b0, key_code}, {28'b0, m_code});
      end
      @(posedge clk); @(negedge clk);
    end
    model_frame(k);
  endtask

  task automatic run_n(input logic [15:0] k, input int n);
    for (int f = 0; f < n; f++) run_frame(k);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_col", {28'b0, col}, 32'hE);
    chk("rst_key_valid", {31'b0, key_valid}, 32'h0);
    chk("rst_key_code", {28'b0, key_code}, 32'h0);
    chk("rst_key_held", {31'b0, key_held}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int seg, len, r;
    logic [15:0] pat;
    @(negedge clk);
    do_reset();

    // single press key 5
    run_n(16'h0000, 2);
    run_n(16'h0020, 6);
    run_n(16'h0000, 5);
    // bounce on key 10, then steady
    for (int f = 0; f < 8; f++) run_frame(f[0] ? 16'h0000 : 16'h0400);
    run_n(16'h0400, 5);
    run_n(16'h0000, 4);
    // two keys 0 and 15, release 15, release all, press key 3
    run_n(16'h8001, 5);
    run_n(16'h0001, 4);
    run_n(16'h0000, 4);
    run_n(16'h0008, 4);
    run_n(16'h0000, 4);
    // key 4 then slide to key 6, release, press 6
    run_n(16'h0010, 5);
    run_n(16'h0040, 5);
    run_n(16'h0000, 4);
    run_n(16'h0040, 4);
    run_n(16'h0000, 4);
    // reset mid-press with key 7 held
    run_n(16'h0080, 5);
    repeat (7) @(negedge clk);
    do_reset();
    run_n(16'h0080, 6);
    run_n(16'h0000, 4);
    // long hold of key 9 (auto-repeat when enabled)
    run_n(16'h0200, 9);
    run_n(16'h0000, 5);

    // randomized segments
    for (seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      pat = 16'h0000;
      else if (r < 8) pat = 16'h1 << $urandom_range(0, 15);
      else            pat = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      len = $urandom_range(1, 5);
      run_n(pat, len);
    end
    run_n(16'h0000, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
